// File: rtl/mano_io_pkg.sv
// mano_io_pkg: shared types and line constants for the basic computer's serial I/O ports
package mano_io_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    localparam int FRAME_BITS = 10;
    localparam int CHAR_W = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL = 1'b1;
endpackage

// File: rtl/bit_timer.sv
// bit_timer: counts clock cycles within one serial bit and pulses tick on the last one
module bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic CLK,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    logic [CW-1:0] cnt;
    assign tick = en && (cnt == CW'(CLKS_PER_BIT - 1));
    // cycle counter: wraps at terminal count so consecutive bits share one timer
    always_ff @(posedge CLK) begin
        if (clr) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/out_port_tx.sv
// out_port_tx: output-port controller; serialises OUT characters as start/8-data/stop frames
module out_port_tx
    import mano_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W = CHAR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] OUTR,
    input  logic              LD,
    input  logic              IEN,
    output logic              FGO,
    output logic              TXD,
    output logic              IRQ,
    output logic              OVR
);
    localparam int BW = $clog2(DATA_W);
    state_t state;
    logic [DATA_W-1:0] shift;
    logic [BW-1:0] bit_cnt;
    logic tick;
    logic accept;
    logic reject;
    logic fgo_next;
    assign accept = LD & FGO;
    assign reject = LD & ~FGO;
    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .CLK (CLK),
        .clr (RST | accept),
        .en  (state != IDLE),
        .tick(tick)
    );
    // flag is raised by the edge that ends the stop bit and dropped by an accepted load
    always_comb fgo_next = RST ? 1'b1 : accept ? 1'b0 : (state == STOP && tick) ? 1'b1 : FGO;
    // frame FSM, shift register, bit counter and registered flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            TXD     <= LINE_IDLE;
            OVR     <= 1'b0;
        end else if (accept) begin
            state   <= START;
            shift   <= OUTR;
            bit_cnt <= '0;
            TXD     <= START_LVL;
            OVR     <= 1'b0;
        end else begin
            if (reject) OVR <= 1'b1;
            if (tick) begin
                case (state)
                    START: begin
                        state <= DATA;
                        TXD   <= shift[0];
                    end
                    DATA: begin
                        shift <= shift >> 1;
                        if (bit_cnt == BW'(DATA_W - 1)) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            TXD     <= STOP_LVL;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            TXD     <= shift[1];
                        end
                    end
                    STOP: begin
                        state <= IDLE;
                        TXD   <= LINE_IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
        FGO <= fgo_next;
        IRQ <= fgo_next & IEN;
    end
endmodule

// File: tb/tb_out_port_tx.sv
// tb_out_port_tx: directed frames checked against a cycle-indexed frame model and literal bit patterns
module tb_out_port_tx;
    localparam int CPB = 4;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [7:0] OUTR = 8'h00;
    logic LD = 1'b0;
    logic IEN = 1'b0;
    logic FGO, TXD, IRQ, OVR;
    int errors = 0;
    int checks = 0;

    out_port_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .OUTR(OUTR), .LD(LD), .IEN(IEN),
        .FGO(FGO), .TXD(TXD), .IRQ(IRQ), .OVR(OVR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: a frame is just a cycle index into {stop, data, start}
    bit m_valid = 1'b0;
    bit m_busy = 1'b0;
    bit m_ovr = 1'b0;
    bit m_irq = 1'b0;
    int m_k = 0;
    logic [7:0] m_byte = 8'h00;

    always @(posedge CLK) begin
        if (RST) begin
            m_valid = 1'b1;
            m_busy = 1'b0;
            m_ovr = 1'b0;
        end else if (LD && !m_busy) begin
            m_busy = 1'b1;
            m_k = 0;
            m_byte = OUTR;
            m_ovr = 1'b0;
        end else begin
            if (LD) m_ovr = 1'b1;
            if (m_busy) begin
                m_k++;
                if (m_k == 10 * CPB) m_busy = 1'b0;
            end
        end
        m_irq = !m_busy && IEN;
    end

    function automatic bit m_txd();
        int b;
        if (!m_busy) return 1'b1;
        b = m_k / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_byte[b-1];
        return 1'b1;
    endfunction

    always @(negedge CLK) begin
        if (m_valid) begin
            chk("model_txd", int'(TXD), int'(m_txd()));
            chk("model_fgo", int'(FGO), int'(!m_busy));
            chk("model_irq", int'(IRQ), int'(m_irq));
            chk("model_ovr", int'(OVR), int'(m_ovr));
        end
    end

    // called at a negedge; leaves at the negedge of cycle 0 of the frame
    task automatic pulse(input logic [7:0] b);
        OUTR = b;
        LD = 1'b1;
        @(negedge CLK);
        LD = 1'b0;
    endtask

    // samples each bit mid-period; optionally injects a rejected load at cycle ovr_at
    task automatic capture(input int ovr_at, output logic [9:0] bits, output int low, output int irq_hi);
        bits = '0;
        low = 0;
        irq_hi = 0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k % CPB == CPB / 2) bits[k/CPB] = TXD;
            if (!FGO) low++;
            if (IRQ) irq_hi++;
            LD = (k == ovr_at);
            if (k == ovr_at) OUTR = 8'h00;
            @(negedge CLK);
        end
        LD = 1'b0;
    endtask

    logic [9:0] bits;
    int low, irq_hi;

    initial begin
        IEN = 1'b1;
        RST = 1'b1;
        LD = 1'b1;
        OUTR = 8'h55;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        LD = 1'b0;
        chk("reset_txd", int'(TXD), 1);
        chk("reset_fgo", int'(FGO), 1);
        chk("reset_ovr", int'(OVR), 0);
        chk("reset_irq", int'(IRQ), 1);
        @(negedge CLK);
        chk("reset_ld_dropped", int'(FGO), 1);

        pulse(8'hA5);
        chk("fgo_latency", int'(FGO), 0);
        capture(-1, bits, low, irq_hi);
        chk("a5_bits", int'(bits), int'(10'b1101001010));
        chk("a5_fgo_low", low, 40);
        chk("a5_fgo_back", int'(FGO), 1);
        chk("a5_irq_low", irq_hi, 0);
        chk("a5_irq_back", int'(IRQ), 1);

        @(negedge CLK);
        pulse(8'hFF);
        capture(-1, bits, low, irq_hi);
        chk("ff_bits", int'(bits), int'(10'b1111111110));
        pulse(8'h3C);
        chk("b2b_start", int'(TXD), 0);
        capture(-1, bits, low, irq_hi);
        chk("3c_bits", int'(bits), int'(10'b1001111000));
        chk("3c_fgo_low", low, 40);

        pulse(8'hA5);
        capture(10, bits, low, irq_hi);
        chk("ovr_bits", int'(bits), int'(10'b1101001010));
        chk("ovr_set", int'(OVR), 1);
        @(negedge CLK);
        chk("ovr_sticky", int'(OVR), 1);
        pulse(8'h5A);
        chk("ovr_clear", int'(OVR), 0);
        capture(-1, bits, low, irq_hi);
        chk("5a_bits", int'(bits), int'(10'b1010110100));

        pulse(8'hC3);
        repeat (17) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("midrst_txd", int'(TXD), 1);
        chk("midrst_fgo", int'(FGO), 1);
        pulse(8'h81);
        capture(-1, bits, low, irq_hi);
        chk("81_bits", int'(bits), int'(10'b1100000010));
        chk("81_fgo_low", low, 40);

        IEN = 1'b0;
        @(negedge CLK);
        pulse(8'h96);
        capture(-1, bits, low, irq_hi);
        chk("ien0_irq", irq_hi, 0);
        chk("ien0_irq_end", int'(IRQ), 0);
        chk("96_bits", int'(bits), int'(10'b1100101100));
        repeat (3) @(negedge CLK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
